// File: rtl/bcd_tick_pkg.sv
// Shared types and default constants for the BCD display tick generator.
package bcd_tick_pkg;

    typedef enum logic [0:0] {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned DEF_DIV        = 33_554_432;
    localparam int unsigned DEF_DEB_CYCLES = 1_000_000;

endpackage

// File: rtl/step_debounce.sv
// Step-button conditioning: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted released->pressed transition.
module step_debounce
    import bcd_tick_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          btn_meta;
    logic          btn_sync;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
            stable   <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            btn_meta <= btn_n;
            btn_sync <= btn_meta;
            press    <= 1'b0;
            if (btn_sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Accept the new level; only released->pressed is an event.
                stable <= ~stable;
                cnt    <= '0;
                press  <= stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_tick_gen.sv
// Count-enable generator for the BCD counter: free-running tick every DIV
// cycles in RUN, one tick per debounced step press in PAUSE.
module bcd_tick_gen
    import bcd_tick_pkg::*;
#(
    parameter int unsigned DIV        = DEF_DIV,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic run_sw,
    input  logic step_btn_n,
    output logic tick,
    output logic running,
    output logic step_ack
);

    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic          run_meta;
    logic          run_sync;
    logic          press;
    logic          terminal;
    state_t        state;
    logic [PW-1:0] presc;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            run_meta <= 1'b0;
            run_sync <= 1'b0;
        end else begin
            run_meta <= run_sw;
            run_sync <= run_meta;
        end
    end

    step_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_debounce (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .btn_n   (step_btn_n),
        .press   (press)
    );

    assign terminal = (presc == PRESC_MAX);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state    <= ST_PAUSE;
            presc    <= '0;
            tick     <= 1'b0;
            running  <= 1'b0;
            step_ack <= 1'b0;
        end else begin
            tick     <= 1'b0;
            step_ack <= press;
            case (state)
                ST_PAUSE: begin
                    if (run_sync) begin
                        // Entering RUN wins over a coincident press.
                        state   <= ST_RUN;
                        presc   <= '0;
                        running <= 1'b1;
                    end else if (press) begin
                        tick <= 1'b1;
                    end
                end
                ST_RUN: begin
                    presc <= terminal ? '0 : presc + 1'b1;
                    tick  <= terminal;
                    if (!run_sync) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_PAUSE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_tick_gen.sv
// Directed bench for bcd_tick_gen with DIV = 4, DEB_CYCLES = 3.
module tb_bcd_tick_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic run_sw;
    logic step_btn_n;
    logic tick;
    logic running;
    logic step_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_tick_gen #(
        .DIV       (4),
        .DEB_CYCLES(3)
    ) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .run_sw    (run_sw),
        .step_btn_n(step_btn_n),
        .tick      (tick),
        .running   (running),
        .step_ack  (step_ack)
    );

    typedef struct {
        logic rst_n;
        logic run;
        logic btn;
        logic tick;
        logic running;
        logic ack;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic ru, input logic b,
                                input logic et, input logic er, input logic ea);
        vec_t v;
        v.rst_n   = r;
        v.run     = ru;
        v.btn     = b;
        v.tick    = et;
        v.running = er;
        v.ack     = ea;
        vecs.push_back(v);
    endfunction

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic ru, input logic b);
        @(negedge clk);
        rst_n      = r;
        run_sw     = ru;
        step_btn_n = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int e, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b, expected %b", nm, e, got, exp);
        end
    endtask

    task automatic chk3(input string nm, input int e,
                        input logic et, input logic ea, input logic er);
        chk({nm, ".tick"}, e, tick, et);
        chk({nm, ".step_ack"}, e, step_ack, ea);
        chk({nm, ".running"}, e, running, er);
    endtask

    initial begin
        rst_n      = 1'b0;
        run_sw     = 1'b1;
        step_btn_n = 1'b1;

        // Reset held with run_sw = 1, then release into RUN.
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e <= 12; e++)
            add(1'b1, 1'b1, 1'b1, e == 6 || e == 10, e >= 2, 1'b0);
        // Reset mid-period, then RUN from PAUSE; run_sync falls on the terminal edge 14.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e <= 20; e++)
            add(1'b1, e < 12, 1'b1, e == 6 || e == 10 || e == 14, e >= 2 && e <= 13, 1'b0);
        // Re-entry, then leave RUN mid-period with the prescaler at 3.
        for (int e = 0; e <= 14; e++)
            add(1'b1, e < 7, 1'b1, e == 6, e >= 2 && e <= 8, 1'b0);
        // Re-entry must restart the period from zero.
        for (int e = 0; e <= 8; e++)
            add(1'b1, 1'b1, 1'b1, e == 6, e >= 2, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst_n, vecs[i].run, vecs[i].btn);
            chk("vec.tick", i, tick, vecs[i].tick);
            chk("vec.running", i, running, vecs[i].running);
            chk("vec.step_ack", i, step_ack, vecs[i].ack);
        end

        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("pause_entry.running", 0, running, 1'b0);

        // Clean 10-cycle press in PAUSE: one tick and ack after edge 5, none on release.
        for (int e = 0; e <= 24; e++) begin
            cyc(1'b1, 1'b0, e >= 10);
            chk3("step_pause", e, e == 5, e == 5, 1'b0);
        end

        // Glitches of 1 and 2 cycles rejected, then a 6-cycle press accepted.
        for (int e = 0; e <= 26; e++) begin
            cyc(1'b1, 1'b0, !(e == 0 || e == 4 || e == 5 || (e >= 9 && e <= 14)));
            chk3("bounce", e, e == 14, e == 14, 1'b0);
        end

        // Press while running: ack only, tick spacing unchanged.
        for (int e = 0; e <= 26; e++) begin
            cyc(1'b1, 1'b1, !(e >= 8 && e <= 12));
            chk3("step_run", e, e >= 6 && (e - 6) % 4 == 0, e == 13, e >= 2);
        end

        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("pause_again.running", 0, running, 1'b0);

        // Press lands on the same edge RUN is entered: ack, no step tick.
        for (int e = 0; e <= 14; e++) begin
            cyc(1'b1, e >= 3, !(e <= 5));
            chk3("press_on_run_entry", e, e == 9 || e == 13, e == 5, e >= 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
